// File: rtl/us_timer_pkg.sv
// Shared types and constants for the shared microsecond interval timer.
package us_timer_pkg;

  localparam int unsigned US_PER_S = 1_000_000;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    RUN,
    DONE
  } state_t;

  function automatic int unsigned cycles_per_us(input int unsigned clk_freq);
    return clk_freq / US_PER_S;
  endfunction

endpackage

// File: rtl/us_tick_gen.sv
// Microsecond prescaler: counts 0..CPU-1 and pulses tick_o on the last count.
module us_tick_gen
  import us_timer_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned   CPU  = cycles_per_us(CLK_FREQ);
  localparam int unsigned   PW   = (CPU > 1) ? $clog2(CPU) : 1;
  localparam logic [PW-1:0] LAST = PW'(CPU - 1);

  logic [PW-1:0] cnt;

  // NOTE: sequential state is updated with <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr_i || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + PW'(1);
    end
  end

  assign tick_o = !clr_i && (cnt == LAST);

endmodule

// File: rtl/us_timer_sched.sv
// Round-robin scheduler sharing one microsecond interval timer between NUM_REQ requesters.
module us_timer_sched
  import us_timer_pkg::*;
#(
  parameter  int unsigned CLK_FREQ = 100_000_000,
  parameter  int unsigned NUM_REQ  = 4,
  parameter  int unsigned MAX_US   = 65535,
  localparam int unsigned DW       = $clog2(MAX_US + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_i,
  input  logic [NUM_REQ*DW-1:0] dur_i,
  output logic [NUM_REQ-1:0]    grant_o,
  output logic [NUM_REQ-1:0]    done_o,
  output logic                  busy_o
);

  localparam int unsigned IW = $clog2(NUM_REQ);

  if (cycles_per_us(CLK_FREQ) == 0 ||
      cycles_per_us(CLK_FREQ) * US_PER_S != CLK_FREQ) begin : g_bad_clk_freq
    $error("us_timer_sched: CLK_FREQ must be a non-zero multiple of 1 MHz");
  end

  if (NUM_REQ < 2) begin : g_bad_num_req
    $error("us_timer_sched: NUM_REQ must be at least 2");
  end

  state_t               state;
  logic [IW-1:0]        owner;
  logic [IW-1:0]        last_grant;
  logic [DW-1:0]        dur;
  logic [DW-1:0]        us_cnt;
  logic                 tick;
  logic                 found;
  logic [IW-1:0]        next_idx;
  logic [NUM_REQ-1:0]   next_onehot;
  logic [DW-1:0]        dur_arr [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign dur_arr[k] = dur_i[k*DW +: DW];
  end

  // Search starts just after the previous owner, so the previous owner ranks last.
  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    found    = 1'b0;
    next_idx = '0;
    for (int i = 1; i <= int'(NUM_REQ); i++) begin
      logic [IW-1:0] cand;
      cand = IW'((int'(last_grant) + i) % int'(NUM_REQ));
      if (!found && req_i[cand]) begin
        found    = 1'b1;
        next_idx = cand;
      end
    end
  end

  assign next_onehot = NUM_REQ'(1) << next_idx;

  us_tick_gen #(
    .CLK_FREQ(CLK_FREQ)
  ) u_tick_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (state != RUN),
    .tick_o (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= '0;
      last_grant <= IW'(NUM_REQ - 1);
      dur        <= '0;
      us_cnt     <= '0;
      grant_o    <= '0;
      done_o     <= '0;
      busy_o     <= 1'b0;
    end else begin
      done_o <= '0;
      if ((state == ARM || state == RUN) && !req_i[owner]) begin
        // Owner withdrew: release silently, and it still counts as the last grant.
        state      <= IDLE;
        last_grant <= owner;
        grant_o    <= '0;
        busy_o     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (found) begin
              owner   <= next_idx;
              dur     <= dur_arr[next_idx];
              grant_o <= next_onehot;
              busy_o  <= 1'b1;
              if (dur_arr[next_idx] == '0) begin
                state  <= DONE;
                done_o <= next_onehot;
              end else begin
                state <= ARM;
              end
            end
          end
          ARM: begin
            us_cnt <= '0;
            state  <= RUN;
          end
          RUN: begin
            if (tick) begin
              if (us_cnt == dur - DW'(1)) begin
                state  <= DONE;
                done_o <= grant_o;
              end else begin
                us_cnt <= us_cnt + DW'(1);
              end
            end
          end
          DONE: begin
            state      <= IDLE;
            last_grant <= owner;
            grant_o    <= '0;
            busy_o     <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_us_timer_sched.sv
// Self-checking bench for us_timer_sched: directed scenarios plus a randomized run
// checked against a transaction-level model (grant intervals computed arithmetically).
module tb_us_timer_sched;

  localparam int unsigned CLK_FREQ = 4_000_000;
  localparam int unsigned NUM_REQ  = 4;
  localparam int unsigned MAX_US   = 15;
  localparam int unsigned DW       = 4;
  localparam int          CPU      = 4;

  logic                  clk   = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NUM_REQ-1:0]    req   = '0;
  logic [NUM_REQ*DW-1:0] dur   = '0;
  logic [NUM_REQ-1:0]    grant;
  logic [NUM_REQ-1:0]    done;
  logic                  busy;

  int n_checks = 0;
  int n_pass   = 0;

  us_timer_sched #(
    .CLK_FREQ(CLK_FREQ),
    .NUM_REQ (NUM_REQ),
    .MAX_US  (MAX_US)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_i   (req),
    .dur_i   (dur),
    .grant_o (grant),
    .done_o  (done),
    .busy_o  (busy)
  );

  always #5 clk = ~clk;

  // Holds r/d through reset and releases on a falling edge; that cycle is cycle 0.
  task automatic do_reset(input logic [3:0] r, input logic [15:0] d);
    @(negedge clk);
    rst_n = 1'b0;
    req   = r;
    dur   = d;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 4'b1111;
    dur   = 16'h1111;
    repeat (2) @(negedge clk);
    if (grant !== 4'b0000) $display("FAIL reset_grant: got %b want 0000", grant);
    else n_pass++;
    n_checks++;
    if (done !== 4'b0000) $display("FAIL reset_done: got %b want 0000", done);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);
    else n_pass++;
    n_checks++;
    req = '0;
  endtask

  task automatic test_single();
    logic [3:0] g_e, d_e;
    logic       b_e;
    do_reset(4'b0001, 16'h0003);
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      g_e = (c <= 14) ? 4'b0001 : 4'b0000;
      d_e = (c == 14) ? 4'b0001 : 4'b0000;
      b_e = (c <= 14);
      if (grant !== g_e) $display("FAIL single_grant c=%0d: got %b want %b", c, grant, g_e);
      else n_pass++;
      n_checks++;
      if (done !== d_e) $display("FAIL single_done c=%0d: got %b want %b", c, done, d_e);
      else n_pass++;
      n_checks++;
      if (busy !== b_e) $display("FAIL single_busy c=%0d: got %b want %b", c, busy, b_e);
      else n_pass++;
      n_checks++;
      if (c == 2) dur[3:0] = 4'd0;   // must not be re-sampled after grant
      if (c == 14) req = 4'b0000;
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] g_e, d_e;
    do_reset(4'b0101, 16'h0101);
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c <= 6)       g_e = 4'b0001;
      else if (c == 7)  g_e = 4'b0000;
      else if (c <= 13) g_e = 4'b0100;
      else if (c == 14) g_e = 4'b0000;
      else              g_e = 4'b0001;
      d_e = (c == 6) ? 4'b0001 : (c == 13) ? 4'b0100 : 4'b0000;
      if (grant !== g_e) $display("FAIL rr_grant c=%0d: got %b want %b", c, grant, g_e);
      else n_pass++;
      n_checks++;
      if (done !== d_e) $display("FAIL rr_done c=%0d: got %b want %b", c, done, d_e);
      else n_pass++;
      n_checks++;
      if (busy !== (g_e != 0)) $display("FAIL rr_busy c=%0d: got %b want %b", c, busy, g_e != 0);
      else n_pass++;
      n_checks++;
    end
    req = '0;
  endtask

  task automatic test_zero_dur();
    logic [3:0] g_e;
    do_reset(4'b1000, 16'h0000);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      g_e = (c == 1) ? 4'b1000 : 4'b0000;
      if (grant !== g_e) $display("FAIL zero_grant c=%0d: got %b want %b", c, grant, g_e);
      else n_pass++;
      n_checks++;
      if (done !== g_e) $display("FAIL zero_done c=%0d: got %b want %b", c, done, g_e);
      else n_pass++;
      n_checks++;
      if (busy !== (c == 1)) $display("FAIL zero_busy c=%0d: got %b want %b", c, busy, c == 1);
      else n_pass++;
      n_checks++;
      if (c == 1) req = 4'b0000;
    end
  endtask

  task automatic test_cancel();
    logic [3:0] g_e, d_e;
    do_reset(4'b0110, 16'h0250);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c <= 7)       g_e = 4'b0010;
      else if (c == 8)  g_e = 4'b0000;
      else if (c <= 18) g_e = 4'b0100;
      else              g_e = 4'b0000;
      d_e = (c == 18) ? 4'b0100 : 4'b0000;
      if (grant !== g_e) $display("FAIL cancel_grant c=%0d: got %b want %b", c, grant, g_e);
      else n_pass++;
      n_checks++;
      if (done !== d_e) $display("FAIL cancel_done c=%0d: got %b want %b", c, done, d_e);
      else n_pass++;
      n_checks++;
      if (busy !== (g_e != 0)) $display("FAIL cancel_busy c=%0d: got %b want %b", c, busy, g_e != 0);
      else n_pass++;
      n_checks++;
      if (c == 7)  req = 4'b0100;
      if (c == 18) req = 4'b0000;
    end
  endtask

  task automatic test_reset_mid_run();
    do_reset(4'b0100, 16'h0400);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (grant !== 4'b0100) $display("FAIL midrst_grant c=%0d: got %b want 0100", c, grant);
      else n_pass++;
      n_checks++;
    end
    req = 4'b1001;
    dur = 16'h2002;
    #2 rst_n = 1'b0;
    #1;
    if (grant !== 4'b0000) $display("FAIL midrst_async_grant: got %b want 0000", grant);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL midrst_async_busy: got %b want 0", busy);
    else n_pass++;
    n_checks++;
    if (done !== 4'b0000) $display("FAIL midrst_async_done: got %b want 0000", done);
    else n_pass++;
    n_checks++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    if (grant !== 4'b0001) $display("FAIL midrst_first_grant: got %b want 0001", grant);
    else n_pass++;
    n_checks++;
    if (done !== 4'b0000) $display("FAIL midrst_first_done: got %b want 0000", done);
    else n_pass++;
    n_checks++;
    req = '0;
  endtask

  task automatic test_max_dur();
    logic [3:0] g_e, d_e;
    do_reset(4'b0001, 16'h000F);
    for (int c = 1; c <= 64; c++) begin
      @(negedge clk);
      g_e = (c <= 62) ? 4'b0001 : 4'b0000;
      d_e = (c == 62) ? 4'b0001 : 4'b0000;
      if (grant !== g_e) $display("FAIL max_grant c=%0d: got %b want %b", c, grant, g_e);
      else n_pass++;
      n_checks++;
      if (done !== d_e) $display("FAIL max_done c=%0d: got %b want %b", c, done, d_e);
      else n_pass++;
      n_checks++;
      if (busy !== (c <= 62)) $display("FAIL max_busy c=%0d: got %b want %b", c, busy, c <= 62);
      else n_pass++;
      n_checks++;
      if (c == 62) req = 4'b0000;
    end
  endtask

  // Model: each grant is an interval (t_start, t_end]; the owner is granted over it,
  // done fires at t_end unless cancelled, and the next search starts at t_end+1.
  task automatic test_random();
    int         t_start, t_end, owner_m, last_m, d, w;
    bit         cancelled;
    int         ready [NUM_REQ];
    logic [3:0] g_e, d_e;
    logic       b_e, active;
    do_reset(4'b0000, 16'h0000);
    t_start   = -10;
    t_end     = -1;
    owner_m   = 0;
    last_m    = NUM_REQ - 1;
    cancelled = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) ready[k] = $urandom_range(0, 8);
    for (int c = 0; c < 2500; c++) begin
      if (c > 0) @(negedge clk);
      active = (c > t_start) && (c <= t_end);
      g_e    = active ? 4'(1 << owner_m) : 4'b0000;
      d_e    = (active && c == t_end && !cancelled) ? 4'(1 << owner_m) : 4'b0000;
      b_e    = active;
      if (grant !== g_e) $display("FAIL rand_grant c=%0d: got %b want %b", c, grant, g_e);
      else n_pass++;
      n_checks++;
      if (done !== d_e) $display("FAIL rand_done c=%0d: got %b want %b", c, done, d_e);
      else n_pass++;
      n_checks++;
      if (busy !== b_e) $display("FAIL rand_busy c=%0d: got %b want %b", c, busy, b_e);
      else n_pass++;
      n_checks++;

      if (active && c == t_end) begin
        ready[owner_m] = c + 1 + $urandom_range(0, 3);
        last_m         = owner_m;
      end else if (active && c > t_start && c < t_end && $urandom_range(0, 99) < 3) begin
        ready[owner_m] = c + 1 + $urandom_range(0, 3);
        last_m         = owner_m;
        cancelled      = 1'b1;
        t_end          = c;
      end

      for (int k = 0; k < NUM_REQ; k++) begin
        req[k]          = (c >= ready[k]);
        dur[k*DW +: DW] = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 5));
      end

      if (c > t_end && req != 0) begin
        w = last_m;
        for (int i = 1; i <= NUM_REQ; i++) begin
          if (req[(last_m + i) % NUM_REQ] && w == last_m && !req[last_m] ||
              req[(last_m + i) % NUM_REQ] && w == last_m && i < NUM_REQ) begin
            w = (last_m + i) % NUM_REQ;
            break;
          end
        end
        d         = int'(dur[w*DW +: DW]);
        owner_m   = w;
        t_start   = c;
        t_end     = (d == 0) ? c + 1 : c + 2 + d * CPU;
        cancelled = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_zero_dur();
    test_cancel();
    test_reset_mid_run();
    test_max_dur();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
